// File: rtl/pkg_entrada_io.sv
// Shared types and default sizing for the IN-path input controller.
package pkg_entrada_io;

   typedef enum logic [1:0] {
      OCIOSO       = 2'd0,
      FILTRO_PRESS = 2'd1,
      PRESSIONADO  = 2'd2,
      FILTRO_SOLTA = 2'd3
   } estado_t;

   localparam int DEBOUNCE_CICLOS_PADRAO = 500000;
   localparam int CONT_W_PADRAO          = 20;
   localparam int DATA_W_PADRAO          = 4;

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchroniser, one independent chain per bit.
module sincronizador_2ff #(
   parameter int W = 1,
   parameter logic [W-1:0] VALOR_RESET = '0
)(
   input  logic         clock,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   genvar gi;
   generate
      for (gi = 0; gi < W; gi++) begin : g_bit
         logic meta_reg;
         logic sinc_reg;

         always_ff @(posedge clock) begin
            if (reset) begin
               meta_reg <= VALOR_RESET[gi];
               sinc_reg <= VALOR_RESET[gi];
            end else begin
               meta_reg <= d[gi];
               sinc_reg <= meta_reg;
            end
         end

         assign q[gi] = sinc_reg;
      end
   endgenerate

endmodule

// File: rtl/controlador_entrada_io.sv
// Button debouncer plus switch capture for the CPU IN instruction:
// a confirmed press latches the switches while an IN is pending.
module controlador_entrada_io
   import pkg_entrada_io::*;
#(
   parameter int DEBOUNCE_CICLOS   = DEBOUNCE_CICLOS_PADRAO,
   parameter int CONT_W            = CONT_W_PADRAO,
   parameter int DATA_W            = DATA_W_PADRAO,
   parameter bit BOTAO_ATIVO_BAIXO = 1'b1
)(
   input  logic              clock,
   input  logic              reset,
   input  logic              botao_bruto,
   input  logic [DATA_W-1:0] chaves_bruto,
   input  logic              pedido_in,
   input  logic              dado_lido,
   output logic              botao_limpo,
   output logic              pulso_botao,
   output logic              dado_valido,
   output logic [DATA_W-1:0] dado_capturado,
   output logic [31:0]       entrada_32,
   output logic              aguardando,
   output logic              sobrescrita
);

   localparam logic [CONT_W-1:0] CONT_MAX = CONT_W'(DEBOUNCE_CICLOS - 1);

   logic              botao_sinc_bruto;
   logic              botao_sinc;
   logic [DATA_W-1:0] chaves_sinc;

   // Button chain resets to the raw "released" level so reset never looks like a press.
   sincronizador_2ff #(
      .W           (1),
      .VALOR_RESET (BOTAO_ATIVO_BAIXO)
   ) u_sinc_botao (
      .clock (clock),
      .reset (reset),
      .d     (botao_bruto),
      .q     (botao_sinc_bruto)
   );

   sincronizador_2ff #(
      .W           (DATA_W),
      .VALOR_RESET ('0)
   ) u_sinc_chaves (
      .clock (clock),
      .reset (reset),
      .d     (chaves_bruto),
      .q     (chaves_sinc)
   );

   assign botao_sinc = botao_sinc_bruto ^ BOTAO_ATIVO_BAIXO;

   estado_t           estado_reg, estado_next;
   logic [CONT_W-1:0] cont_reg, cont_next;
   logic              confirma;

   always_ff @(posedge clock) begin
      if (reset) begin
         estado_reg <= OCIOSO;
         cont_reg   <= '0;
      end else begin
         estado_reg <= estado_next;
         cont_reg   <= cont_next;
      end
   end

   always_comb begin
      estado_next = estado_reg;
      cont_next   = cont_reg;
      confirma    = 1'b0;
      case (estado_reg)
         OCIOSO: begin
            if (botao_sinc) begin
               estado_next = FILTRO_PRESS;
               cont_next   = '0;
            end
         end
         FILTRO_PRESS: begin
            if (!botao_sinc) begin
               estado_next = OCIOSO;
               cont_next   = '0;
            end else if (cont_reg == CONT_MAX) begin
               estado_next = PRESSIONADO;
               cont_next   = '0;
               confirma    = 1'b1;
            end else begin
               cont_next = cont_reg + CONT_W'(1);
            end
         end
         PRESSIONADO: begin
            if (!botao_sinc) begin
               estado_next = FILTRO_SOLTA;
               cont_next   = '0;
            end
         end
         FILTRO_SOLTA: begin
            // Returning to pressed is a bounce of the release, not a new press.
            if (botao_sinc) begin
               estado_next = PRESSIONADO;
               cont_next   = '0;
            end else if (cont_reg == CONT_MAX) begin
               estado_next = OCIOSO;
               cont_next   = '0;
            end else begin
               cont_next = cont_reg + CONT_W'(1);
            end
         end
         default: begin
            estado_next = OCIOSO;
            cont_next   = '0;
         end
      endcase
   end

   logic              pulso_reg;
   logic              dado_valido_reg;
   logic [DATA_W-1:0] dado_reg;
   logic              sobrescrita_reg;

   always_ff @(posedge clock) begin
      if (reset) begin
         pulso_reg       <= 1'b0;
         dado_valido_reg <= 1'b0;
         dado_reg        <= '0;
         sobrescrita_reg <= 1'b0;
      end else begin
         pulso_reg <= confirma;
         // An ack on the confirm cycle frees the slot, so the press is a fresh capture.
         if (confirma && pedido_in && (!dado_valido_reg || dado_lido)) begin
            dado_reg        <= chaves_sinc;
            dado_valido_reg <= 1'b1;
            sobrescrita_reg <= 1'b0;
         end else if (confirma && pedido_in) begin
            sobrescrita_reg <= 1'b1;
         end else if (dado_lido && dado_valido_reg) begin
            dado_valido_reg <= 1'b0;
            sobrescrita_reg <= 1'b0;
         end
      end
   end

   assign botao_limpo    = (estado_reg == PRESSIONADO) || (estado_reg == FILTRO_SOLTA);
   assign pulso_botao    = pulso_reg;
   assign dado_valido    = dado_valido_reg;
   assign dado_capturado = dado_reg;
   assign sobrescrita    = sobrescrita_reg;
   assign aguardando     = pedido_in & ~dado_valido_reg;
   assign entrada_32     = {{(32 - DATA_W){1'b0}}, dado_reg};

endmodule

// File: doc/controlador_entrada_io.md
Name: controlador_entrada_io

Overview:
- Input front-end that feeds the CPU's IN path (botaoIN, entradaDeDados) and the ledin indicator.
- Synchronises the raw board push-button and the 4 data switches.
- Debounces the button with a 4-state FSM and emits a single-cycle confirmed-press pulse.
- Captures the switch value on a confirmed press while the CPU has an IN pending, and holds it valid until the CPU acknowledges the read.

Parameters:
- DEBOUNCE_CICLOS, 500000: consecutive stable cycles required to confirm a press or a release (≥2).
- CONT_W, 20: debounce counter width; must satisfy 2^CONT_W > DEBOUNCE_CICLOS.
- DATA_W, 4: switch/data width.
- BOTAO_ATIVO_BAIXO, 1: 1 means raw button reads 0 when pressed.

Ports:
- clock  in  1  system clock (single domain)
- reset  in  1  synchronous, active-high
- botao_bruto  in  1  raw, asynchronous push-button
- chaves_bruto  in  DATA_W  raw, asynchronous switches
- pedido_in  in  1  level; CPU is executing IN and waiting for data
- dado_lido  in  1  one-cycle ack; CPU consumed dado_capturado
- botao_limpo  out  1  debounced button level (1 = pressed)
- pulso_botao  out  1  one-cycle pulse per confirmed press
- dado_valido  out  1  dado_capturado holds unread data
- dado_capturado  out  DATA_W  captured switch value
- entrada_32  out  32  dado_capturado zero-extended to 32 bits
- aguardando  out  1  pedido_in & ~dado_valido (drives ledin)
- sobrescrita  out  1  sticky overrun flag

Behaviour:
- Interface decisions: one clock, clock; reset is synchronous and active-high, named reset.
- Reset values: botao_limpo=0, pulso_botao=0, dado_valido=0, dado_capturado=0, sobrescrita=0, counter=0, FSM=OCIOSO, synchroniser flops=released/0.
- Synchronisers:
  - 2-flop synchronisers on botao_bruto and chaves_bruto.
  - Polarity is normalised after synchronisation: pressed = 1 internally.
- FSM states:
  - OCIOSO: released stable; botao_limpo=0.
  - FILTRO_PRESS: confirming a press.
  - PRESSIONADO: pressed stable; botao_limpo=1.
  - FILTRO_SOLTA: confirming a release.
- Transitions:
  - OCIOSO -> FILTRO_PRESS when sync=1; counter cleared.
  - FILTRO_PRESS -> OCIOSO when sync=0 (bounce); counter cleared.
  - FILTRO_PRESS -> PRESSIONADO when sync=1 and counter==DEBOUNCE_CICLOS-1. Otherwise the counter increments.
  - PRESSIONADO -> FILTRO_SOLTA when sync=0; counter cleared.
  - FILTRO_SOLTA -> PRESSIONADO when sync=1.
  - FILTRO_SOLTA -> OCIOSO when sync=0 and counter==DEBOUNCE_CICLOS-1.
- Counter behaviour: the counter never exceeds DEBOUNCE_CICLOS-1 and never wraps.
- pulso_botao:
  - Registered; high for exactly the first cycle in PRESSIONADO.
  - With a clean press, pulso_botao rises DEBOUNCE_CICLOS+2 rising edges after the first edge that samples the press. The +2 comes from the synchroniser.
  - Release never pulses.
- Capture, evaluated on the press-confirm cycle:
  - pedido_in=1 and dado_valido=0: dado_capturado <= synchronised switches and dado_valido <= 1 on the same edge that raises pulso_botao.
  - pedido_in=1 and dado_valido=1 (and no simultaneous dado_lido): old data is kept and sobrescrita <= 1.
  - pedido_in=0: pulse only; no capture and no flag change.
- Ack:
  - dado_lido with dado_valido=1 clears dado_valido and sobrescrita on the next edge.
  - dado_lido with dado_valido=0 is ignored.
  - Simultaneous ack and qualifying confirm: the new data is captured and dado_valido stays 1. This counts as a fresh capture, so no overrun and sobrescrita is cleared.
- aguardando and entrada_32 are combinational from registers and pedido_in.
- Reset mid-filter:
  - All state returns to reset values.
  - A button held through reset re-filters from OCIOSO and yields exactly one pulse.
- Width rule: entrada_32 = {(32-DATA_W) zeros, dado_capturado}.

Decomposition:
- Package pkg_entrada_io:
  - FSM state typedef: OCIOSO=2'd0, FILTRO_PRESS=2'd1, PRESSIONADO=2'd2, FILTRO_SOLTA=2'd3.
  - Default DEBOUNCE_CICLOS and DATA_W constants.
- Sub-module sincronizador_2ff (parameter W), instantiated once for the button (W=1) and once for the switches (W=DATA_W).

Test Plan (DEBOUNCE_CICLOS=4, BOTAO_ATIVO_BAIXO=1):
- Clean press: botao_bruto held 0, chaves_bruto=4'd9, pedido_in=1 -> pulso_botao high 1 cycle, 6 edges after first sampling edge; dado_valido=1, entrada_32=32'd9, aguardando=0.
- Bounce: botao_bruto 0 for 3 cycles, 1 for 1 cycle, repeated 5 times -> no pulso_botao, botao_limpo stays 0, counter returns to 0 on each bounce.
- Overrun: capture 4'd3, then a second confirmed press with chaves_bruto=4'd7 and no dado_lido -> dado_capturado stays 3, sobrescrita=1; then dado_lido -> dado_valido=0, sobrescrita=0.
- Simultaneous ack and confirm: dado_valido=1 with data 4'd2; dado_lido asserted on the confirm cycle with switches=4'd5 -> dado_capturado=5, dado_valido=1, sobrescrita=0.
- No request: pedido_in=0 and a confirmed press -> pulso_botao=1, dado_valido stays 0, aguardando=0.
- Reset mid-filter: reset asserted at counter=2 while the button stays held -> outputs at reset values next edge; exactly one pulse 6 edges after reset deasserts; a long hold gives no further pulses until release is confirmed after 4 stable released cycles.
